pixel_word_server: RTL and testbench

- Responder side of the x/y pixel-read handshake used by the blob measurement blocks (area, bounding, centroid scanners).
- Accepts a pixel coordinate from one scanner and returns the 1-bit pixel value with a ready strobe.
- Fetches packed 8-pixel words from the synchronous binary image memory on the read port.
- Keeps a one-word line buffer so a raster scan hits on 7 of every 8 pixels.

---
 rtl/pixel_mem_pkg.sv | 27 ++
 rtl/pixel_addr_gen.sv | 30 +++
 rtl/pixel_word_server.sv | 112 +++++++++++
 tb/tb_pixel_word_server.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_mem_pkg.sv
// Shared definitions for the packed binary image memory: geometry defaults,
// coordinate/address types, the x,y -> word address mapping and FSM states.
package pixel_mem_pkg;

  localparam int IMG_W_DFLT    = 640;
  localparam int IMG_H_DFLT    = 480;
  localparam int WORD_W_DFLT   = 8;
  localparam int ADDR_W_DFLT   = 16;
  localparam int WORDS_PER_ROW = IMG_W_DFLT / WORD_W_DFLT;
  localparam int WORD_SHIFT    = $clog2(WORD_W_DFLT);

  typedef logic [9:0]             coord_t;
  typedef logic [ADDR_W_DFLT-1:0] mem_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2
  } state_t;

  // Word address of pixel (px,py) for the default geometry; shift plus a
  // constant multiply keeps this free of any divider.
  function automatic mem_addr_t pixel_addr(input coord_t px, input coord_t py);
    return mem_addr_t'(py) * mem_addr_t'(WORDS_PER_ROW) + mem_addr_t'(px >> WORD_SHIFT);
  endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// Combinational pixel coordinate decoder: word address, bit within the word,
// and whether the coordinate lies inside the image.
module pixel_addr_gen
  import pixel_mem_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DFLT,
  parameter int IMG_H  = IMG_H_DFLT,
  parameter int WORD_W = WORD_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
) (
  input  coord_t                     x,
  input  coord_t                     y,
  output logic [ADDR_W-1:0]          addr,
  output logic [$clog2(WORD_W)-1:0]  bit_idx,
  output logic                       in_range
);

  localparam int          SHIFT = $clog2(WORD_W);
  localparam int          WPR   = IMG_W / WORD_W;
  localparam logic [31:0] W_LIM = IMG_W;
  localparam logic [31:0] H_LIM = IMG_H;

  // Address = row * words-per-row + column word; bit = column mod word width.
  always_comb begin
    addr     = ADDR_W'(y) * ADDR_W'(WPR) + ADDR_W'(x >> SHIFT);
    bit_idx  = x[SHIFT-1:0];
    in_range = ({22'd0, x} < W_LIM) && ({22'd0, y} < H_LIM);
  end

endmodule

// File: rtl/pixel_word_server.sv
// Answers x/y pixel requests from a blob scanner out of a one-word line
// buffer, fetching packed words from the synchronous image memory on a miss.
module pixel_word_server
  import pixel_mem_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DFLT,
  parameter int IMG_H      = IMG_H_DFLT,
  parameter int WORD_W     = WORD_W_DFLT,
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  coord_t            x,
  input  coord_t            y,
  output logic              pixel,
  output logic              ready,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [WORD_W-1:0] rdata,
  output logic [15:0]       miss_count
);

  localparam int         BIT_W = $clog2(WORD_W);
  localparam logic [1:0] LAT   = 2'(RD_LATENCY);

  state_t              state_q;
  logic                line_valid_q;
  logic                discard_q;
  logic [ADDR_W-1:0]   tag_q;
  logic [WORD_W-1:0]   line_q;
  logic [ADDR_W-1:0]   rdaddress_q;
  logic [1:0]          wait_cnt_q;
  logic [15:0]         miss_count_q;
  logic [15:0]         miss_count_d;

  logic [ADDR_W-1:0]   req_addr;
  logic [BIT_W-1:0]    req_bit;
  logic                req_in_range;
  logic                tag_match;
  logic                hit;
  logic                miss;

  pixel_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .x        (x),
    .y        (y),
    .addr     (req_addr),
    .bit_idx  (req_bit),
    .in_range (req_in_range)
  );

  // Hit/miss decode and the combinational ready/pixel response. An
  // invalidate in IDLE suppresses both the hit and a new fetch that cycle,
  // so the next request re-evaluates against the rewritten image.
  always_comb begin
    tag_match    = line_valid_q && (tag_q == req_addr);
    hit          = (state_q == IDLE) && req_in_range && tag_match && !invalidate;
    miss         = (state_q == IDLE) && req_in_range && !tag_match && !invalidate;
    ready        = hit || (!req_in_range && (state_q != FILL));
    pixel        = hit ? line_q[req_bit] : 1'b0;
    miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
  end

  // Fetch FSM: IDLE issues the read, WAIT covers the memory latency, FILL
  // captures the word; invalidates seen mid-fetch mark the fill as stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      line_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      tag_q        <= '0;
      line_q       <= '0;
      rdaddress_q  <= '0;
      wait_cnt_q   <= 2'd0;
      miss_count_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (invalidate) line_valid_q <= 1'b0;
          if (miss) begin
            rdaddress_q  <= req_addr;
            miss_count_q <= miss_count_d;
            wait_cnt_q   <= LAT;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (invalidate) discard_q <= 1'b1;
          wait_cnt_q <= wait_cnt_q - 2'd1;
          if (wait_cnt_q <= 2'd1) state_q <= FILL;
        end
        FILL: begin
          line_q       <= rdata;
          tag_q        <= rdaddress_q;
          line_valid_q <= !(discard_q || invalidate);
          discard_q    <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdaddress  = rdaddress_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_pixel_word_server.sv
// Directed bench for pixel_word_server with a 1-cycle synchronous memory model.
module tb_pixel_word_server;

  logic        clk;
  logic        reset_n;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pixel;
  logic        ready;
  logic        invalidate;
  logic [15:0] rdaddress;
  logic [7:0]  rdata;
  logic [15:0] miss_count;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  pixel_word_server dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .pixel      (pixel),
    .ready      (ready),
    .invalidate (invalidate),
    .rdaddress  (rdaddress),
    .rdata      (rdata),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous image memory, one cycle read latency.
  always @(posedge clk) rdata <= mem[rdaddress];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until ready (bounded), then accept on the
  // next edge. cyc = number of edges waited before ready was seen.
  task automatic request(input logic [9:0] rx, input logic [9:0] ry,
                         output logic pix, output int cyc);
    x = rx;
    y = ry;
    cyc = 0;
    #1;
    while (ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("req_ready", 32'(ready), 32'd1);
    pix = pixel;
    tick();
  endtask

  function automatic logic exp_pix(input int px, input int py);
    return (px == 7 && py == 2) || (px == 3 && py == 3) ||
           (px == 9 && py == 4) || (px == 5 && py == 5);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p;
    int   c;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[160] = 8'h80;
    mem[240] = 8'h08;
    mem[321] = 8'h02;
    mem[400] = 8'h20;
    reset_n = 1'b0;
    invalidate = 1'b0;
    x = 10'd0;
    y = 10'd0;
    #11;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_rdaddr", 32'(rdaddress), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);

    // First miss: (7,2) -> addr 160 bit 7, ready at t+3.
    x = 10'd7;
    y = 10'd2;
    #1;
    reset_n = 1'b1;
    #1;
    chk("m1_ready_t", 32'(ready), 32'd0);
    tick();
    chk("m1_rdaddr", 32'(rdaddress), 32'd160);
    chk("m1_miss", 32'(miss_count), 32'd1);
    chk("m1_ready_t1", 32'(ready), 32'd0);
    tick();
    chk("m1_ready_t2", 32'(ready), 32'd0);
    tick();
    chk("m1_ready_t3", 32'(ready), 32'd1);
    chk("m1_pixel", 32'(pixel), 32'd1);
    tick();

    // Fresh start, then raster 10x10 and one row past.
    reset_n = 1'b0;
    x = 10'd0;
    y = 10'd0;
    #2;
    chk("rst2_miss", 32'(miss_count), 32'd0);
    reset_n = 1'b1;
    for (int ry = 0; ry < 10; ry++) begin
      for (int rx = 0; rx < 10; rx++) begin
        request(10'(rx), 10'(ry), p, c);
        chk($sformatf("raster_pix_%0d_%0d", rx, ry), 32'(p), 32'(exp_pix(rx, ry)));
        chk($sformatf("raster_lat_%0d_%0d", rx, ry), 32'(c), (rx % 8 == 0) ? 32'd3 : 32'd0);
      end
    end
    request(10'd0, 10'd10, p, c);
    chk("row10_pix", 32'(p), 32'd0);
    chk("row10_lat", 32'(c), 32'd3);
    chk("raster_miss", 32'(miss_count), 32'd21);

    // Out of range responds immediately with 0 and no fetch.
    x = 10'd0;
    y = 10'd480;
    #1;
    chk("oor_y_ready", 32'(ready), 32'd1);
    chk("oor_y_pixel", 32'(pixel), 32'd0);
    x = 10'd640;
    y = 10'd0;
    #1;
    chk("oor_x_ready", 32'(ready), 32'd1);
    chk("oor_x_pixel", 32'(pixel), 32'd0);
    tick();
    chk("oor_miss", 32'(miss_count), 32'd21);

    // Coordinates change during WAIT: old address still fills.
    x = 10'd3;
    y = 10'd3;
    tick();
    chk("chg_rdaddr", 32'(rdaddress), 32'd240);
    chk("chg_miss", 32'(miss_count), 32'd22);
    x = 10'd9;
    y = 10'd4;
    tick();
    chk("chg_fill_ready", 32'(ready), 32'd0);
    tick();
    x = 10'd3;
    y = 10'd3;
    #1;
    chk("chg_oldtag_ready", 32'(ready), 32'd1);
    chk("chg_oldtag_pixel", 32'(pixel), 32'd1);
    x = 10'd9;
    y = 10'd4;
    #1;
    chk("chg_newmiss_ready", 32'(ready), 32'd0);
    tick();
    request(10'd9, 10'd4, p, c);
    chk("chg_pix", 32'(p), 32'd1);
    chk("chg_lat", 32'(c), 32'd2);
    chk("chg_miss2", 32'(miss_count), 32'd23);

    // Invalidate in IDLE after a hit; rewritten word is refetched.
    request(10'd5, 10'd5, p, c);
    chk("inv_first_pix", 32'(p), 32'd1);
    request(10'd5, 10'd5, p, c);
    chk("inv_hit_pix", 32'(p), 32'd1);
    chk("inv_hit_lat", 32'(c), 32'd0);
    invalidate = 1'b1;
    #1;
    chk("inv_ready", 32'(ready), 32'd0);
    tick();
    invalidate = 1'b0;
    mem[400] = 8'h00;
    request(10'd5, 10'd5, p, c);
    chk("inv_refetch_pix", 32'(p), 32'd0);
    chk("inv_refetch_lat", 32'(c), 32'd3);
    chk("inv_miss", 32'(miss_count), 32'd25);

    // Invalidate during WAIT: fill lands but is not valid.
    x = 10'd9;
    y = 10'd4;
    #1;
    chk("invw_ready0", 32'(ready), 32'd0);
    tick();
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    chk("invw_fill_ready", 32'(ready), 32'd0);
    tick();
    chk("invw_idle_ready", 32'(ready), 32'd0);
    chk("invw_miss", 32'(miss_count), 32'd26);
    request(10'd9, 10'd4, p, c);
    chk("invw_pix", 32'(p), 32'd1);
    chk("invw_lat", 32'(c), 32'd3);
    chk("invw_miss2", 32'(miss_count), 32'd27);

    // Invalidate coincident with the FILL edge wins.
    x = 10'd3;
    y = 10'd3;
    tick();
    tick();
    invalidate = 1'b1;
    chk("invf_fill_ready", 32'(ready), 32'd0);
    tick();
    invalidate = 1'b0;
    chk("invf_idle_ready", 32'(ready), 32'd0);
    chk("invf_miss", 32'(miss_count), 32'd28);
    request(10'd3, 10'd3, p, c);
    chk("invf_pix", 32'(p), 32'd1);
    chk("invf_lat", 32'(c), 32'd3);
    chk("invf_miss2", 32'(miss_count), 32'd29);

    // Asynchronous reset in WAIT clears everything at once.
    x = 10'd7;
    y = 10'd2;
    tick();
    chk("arst_rdaddr_pre", 32'(rdaddress), 32'd160);
    chk("arst_miss_pre", 32'(miss_count), 32'd30);
    reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_miss", 32'(miss_count), 32'd0);
    chk("arst_rdaddr", 32'(rdaddress), 32'd0);
    #2;
    reset_n = 1'b1;
    request(10'd7, 10'd2, p, c);
    chk("arst_refetch_pix", 32'(p), 32'd1);
    chk("arst_refetch_lat", 32'(c), 32'd3);
    chk("arst_refetch_miss", 32'(miss_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
